dot_quad: RTL and testbench

Four independent, identical pipelined lanes, each computing an 8-bit two-input dot product plus offset: `out = m + a0*b0 + a1*b1` (mod 2^8). Operands enter the lane in a skewed, systolic fashion, one term per cycle, so each lane maps onto a cascaded multiply-add chain. The block sits in the datapath as a small fixed-function MAC array with a shared clock enable.

---
 rtl/dot_quad_pkg.sv | 9 +
 rtl/dot_quad_lane.sv | 50 +++++
 rtl/dot_quad.sv | 85 ++++++++
 tb/tb_dot_quad.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dot_quad_pkg.sv
// dot_quad_pkg: constants shared by the dot_quad MAC array.
//   DATA_W     - width of every operand, offset, product, sum and result
//   LANE_COUNT - number of independent lanes in the array
package dot_quad_pkg;

  localparam int DATA_W     = 8;
  localparam int LANE_COUNT = 4;

endpackage

// File: rtl/dot_quad_lane.sv
// dot_lane: one pipelined dot-product-plus-offset lane,
//   out = offset + x0*y0 + x1*y1 (mod 2^DATA_W)
// Operands arrive skewed: pair 0 at edge T, pair 1 at T+1, offset at T+2,
// result registered on out after edge T+3. All arithmetic wraps.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; clears the whole pipeline, beats en
//   en     - clock enable for every pipeline register
//   x0, y0 - first operand pair (stage 0)
//   x1, y1 - second operand pair (stage 1)
//   offset - offset term (stage 2)
//   out    - registered result
module dot_lane
  import dot_quad_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] y0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] y1,
  input  logic [DATA_W-1:0] offset,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;
  logic [DATA_W-1:0] q2;
  logic [DATA_W-1:0] r;

  // Expressions are evaluated at DATA_W bits, so products and sums wrap
  // naturally; signed and unsigned operands give the same low bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
      r  <= '0;
    end else if (en) begin
      q0 <= x0 * y0;
      q1 <= q0 + x1 * y1;
      q2 <= q1 + offset;
      r  <= q2;
    end
  end

  assign out = r;

endmodule

// File: rtl/dot_quad.sv
// dot_quad: four identical, independent dot_lane instances sharing only
// clock, reset and en.
// Ports:
//   clock, reset, en       - shared clock, synchronous active-high reset, enable
//   m, a0, b0, a1, b1      - lane w offset and operand pairs
//   n, c0, d0, c1, d1      - lane x offset and operand pairs
//   o, e0, f0, e1, f1      - lane y offset and operand pairs
//   p, g0, h0, g1, h1      - lane z offset and operand pairs
//   w, x, y, z             - registered lane results
module dot_quad
  import dot_quad_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] m,
  input  logic [DATA_W-1:0] n,
  input  logic [DATA_W-1:0] o,
  input  logic [DATA_W-1:0] p,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] c0,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] c1,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] e0,
  input  logic [DATA_W-1:0] f0,
  input  logic [DATA_W-1:0] e1,
  input  logic [DATA_W-1:0] f1,
  input  logic [DATA_W-1:0] g0,
  input  logic [DATA_W-1:0] h0,
  input  logic [DATA_W-1:0] g1,
  input  logic [DATA_W-1:0] h1,
  output logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] z
);

  // Lane index 0..3 maps to w, x, y, z.
  logic [DATA_W-1:0] lane_x0     [LANE_COUNT];
  logic [DATA_W-1:0] lane_y0     [LANE_COUNT];
  logic [DATA_W-1:0] lane_x1     [LANE_COUNT];
  logic [DATA_W-1:0] lane_y1     [LANE_COUNT];
  logic [DATA_W-1:0] lane_offset [LANE_COUNT];
  logic [DATA_W-1:0] lane_out    [LANE_COUNT];

  assign lane_x0[0] = a0;  assign lane_y0[0] = b0;
  assign lane_x1[0] = a1;  assign lane_y1[0] = b1;
  assign lane_offset[0] = m;

  assign lane_x0[1] = c0;  assign lane_y0[1] = d0;
  assign lane_x1[1] = c1;  assign lane_y1[1] = d1;
  assign lane_offset[1] = n;

  assign lane_x0[2] = e0;  assign lane_y0[2] = f0;
  assign lane_x1[2] = e1;  assign lane_y1[2] = f1;
  assign lane_offset[2] = o;

  assign lane_x0[3] = g0;  assign lane_y0[3] = h0;
  assign lane_x1[3] = g1;  assign lane_y1[3] = h1;
  assign lane_offset[3] = p;

  for (genvar i = 0; i < LANE_COUNT; i++) begin : g_lane
    dot_lane u_lane (
      .clock  (clock),
      .reset  (reset),
      .en     (en),
      .x0     (lane_x0[i]),
      .y0     (lane_y0[i]),
      .x1     (lane_x1[i]),
      .y1     (lane_y1[i]),
      .offset (lane_offset[i]),
      .out    (lane_out[i])
    );
  end

  assign w = lane_out[0];
  assign x = lane_out[1];
  assign y = lane_out[2];
  assign z = lane_out[3];

endmodule

// File: tb/tb_dot_quad.sv
// tb_dot_quad: directed bench for dot_quad with hand-computed results.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dot_quad;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] m, n, o, p;
  logic [7:0] a0, b0, a1, b1;
  logic [7:0] c0, d0, c1, d1;
  logic [7:0] e0, f0, e1, f1;
  logic [7:0] g0, h0, g1, h1;
  logic [7:0] w, x, y, z;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dot_quad dut (
    .clock (clock), .reset (reset), .en (en),
    .m (m), .n (n), .o (o), .p (p),
    .a0 (a0), .b0 (b0), .a1 (a1), .b1 (b1),
    .c0 (c0), .d0 (d0), .c1 (c1), .d1 (d1),
    .e0 (e0), .f0 (f0), .e1 (e1), .f1 (f1),
    .g0 (g0), .h0 (h0), .g1 (g1), .h1 (h1),
    .w (w), .x (x), .y (y), .z (z)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%02h expected=0x%02h", tag, got, exp);
    end
  endtask

  task automatic check_lanes(input string tag, input logic [7:0] ew, input logic [7:0] ex,
                             input logic [7:0] ey, input logic [7:0] ez);
    check({tag, ".w"}, w, ew);
    check({tag, ".x"}, x, ex);
    check({tag, ".y"}, y, ey);
    check({tag, ".z"}, z, ez);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_lane(input int l, input logic [7:0] u0, input logic [7:0] v0,
                          input logic [7:0] u1, input logic [7:0] v1, input logic [7:0] off);
    case (l)
      0: begin a0 = u0; b0 = v0; a1 = u1; b1 = v1; m = off; end
      1: begin c0 = u0; d0 = v0; c1 = u1; d1 = v1; n = off; end
      2: begin e0 = u0; f0 = v0; e1 = u1; f1 = v1; o = off; end
      default: begin g0 = u0; h0 = v0; g1 = u1; h1 = v1; p = off; end
    endcase
  endtask

  task automatic feed(input logic [7:0] u0, input logic [7:0] v0,
                      input logic [7:0] u1, input logic [7:0] v1, input logic [7:0] off);
    for (int l = 0; l < 4; l++) set_lane(l, u0, v0, u1, v1, off);
  endtask

  task automatic clean_reset();
    feed(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    en    = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    feed(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    // Reset hold with a0=-2, b0=3 applied; the product only surfaces 4 edges after release.
    set_lane(0, 8'hFE, 8'd3, 8'd0, 8'd0, 8'd0);
    @(negedge clock);
    step();
    check_lanes("rst_hold0", 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    check_lanes("rst_hold1", 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_lanes($sformatf("rst_rel%0d", i), 8'h00, 8'h00, 8'h00, 8'h00);
    end
    step();
    check("rst_rel3.w", w, 8'hFA);

    // Skewed operation with overlapped second operation in all lanes.
    clean_reset();
    feed(8'hFE, 8'd3, 8'd0, 8'd0, 8'd0);   step();   // T
    feed(8'd1, 8'd2, 8'd7, 8'd2, 8'd0);    step();   // T+1
    feed(8'd0, 8'd0, 8'hFD, 8'd4, 8'd3);   step();   // T+2
    check_lanes("skew_t2", 8'h00, 8'h00, 8'h00, 8'h00);
    feed(8'd0, 8'd0, 8'd0, 8'd0, 8'd9);    step();   // T+3
    check_lanes("skew_res", 8'h0B, 8'h0B, 8'h0B, 8'h0B);
    feed(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);    step();   // T+4
    check_lanes("overlap_res", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    step();
    check_lanes("drain", 8'h00, 8'h00, 8'h00, 8'h00);

    // Wrap-around and lane independence: different operands per lane.
    clean_reset();
    set_lane(0, 8'd16,  8'd16, 8'd0, 8'd0, 8'd0);
    set_lane(1, 8'd127, 8'd2,  8'd0, 8'd0, 8'd0);
    set_lane(2, 8'd3,   8'd5,  8'd0, 8'd0, 8'd0);
    set_lane(3, 8'd200, 8'd3,  8'd0, 8'd0, 8'd0);
    step();
    set_lane(0, 8'd0, 8'd0, 8'd0,   8'd0, 8'd0);
    set_lane(1, 8'd0, 8'd0, 8'd1,   8'd1, 8'd0);
    set_lane(2, 8'd0, 8'd0, 8'd2,   8'd4, 8'd0);
    set_lane(3, 8'd0, 8'd0, 8'd100, 8'd3, 8'd0);
    step();
    set_lane(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5);
    set_lane(1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    set_lane(2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10);
    set_lane(3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7);
    step();
    feed(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    check_lanes("wrap", 8'h05, 8'hFF, 8'h21, 8'h8B);

    // Enable stall: freeze with 11 on the outputs and -1 in flight.
    clean_reset();
    feed(8'hFE, 8'd3, 8'd0, 8'd0, 8'd0);   step();
    feed(8'd1, 8'd2, 8'd7, 8'd2, 8'd0);    step();
    feed(8'd0, 8'd0, 8'hFD, 8'd4, 8'd3);   step();
    feed(8'd0, 8'd0, 8'd0, 8'd0, 8'd9);    step();
    check_lanes("stall_pre", 8'h0B, 8'h0B, 8'h0B, 8'h0B);
    en = 1'b0;
    feed(8'h55, 8'h33, 8'h77, 8'h11, 8'h99);
    for (int i = 0; i < 3; i++) begin
      step();
      check_lanes($sformatf("stall%0d", i), 8'h0B, 8'h0B, 8'h0B, 8'h0B);
    end
    en = 1'b1;
    feed(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    check_lanes("stall_resume", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Reset one cycle before the result appears, with en low to show reset wins.
    clean_reset();
    feed(8'hFE, 8'd3, 8'd0, 8'd0, 8'd0);   step();
    feed(8'd0, 8'd0, 8'd7, 8'd2, 8'd0);    step();
    feed(8'd0, 8'd0, 8'd0, 8'd0, 8'd3);    step();
    feed(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    en    = 1'b0;
    reset = 1'b1;
    step();
    check_lanes("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_lanes($sformatf("rst_lost%0d", i), 8'h00, 8'h00, 8'h00, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
